// File: rtl/alu_writeback_rf_if.sv
// Issue-side and ALU-side signal bundle for the ALU writeback/register-file stage.
// Latency: none (wires only).
// Backpressure: issue_ready from the slave gates acceptance of issue_valid.
interface alu_writeback_rf_if #(
  parameter int AW = 4
);
  // issue handshake
  logic          issue_valid;
  logic          issue_ready;
  logic [7:0]    issue_opcode;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] issue_rr;
  // operands toward the ALU
  logic [7:0]    alu_data_rd;
  logic [7:0]    alu_data_rr;
  logic          alu_ci;
  logic [7:0]    alu_opcode;
  // results back from the ALU
  logic [15:0]   alu_data;
  logic          alu_co;
  logic          alu_no;
  logic          alu_zo;

  // Issuer / ALU-result side
  modport master (
    output issue_valid, issue_opcode, issue_rd, issue_rr,
    output alu_data, alu_co, alu_no, alu_zo,
    input  issue_ready, alu_data_rd, alu_data_rr, alu_ci, alu_opcode
  );

  // Register-file / writeback stage side
  modport slave (
    input  issue_valid, issue_opcode, issue_rd, issue_rr,
    input  alu_data, alu_co, alu_no, alu_zo,
    output issue_ready, alu_data_rd, alu_data_rr, alu_ci, alu_opcode
  );
endinterface

// File: rtl/alu_writeback_rf.sv
// Register file, hazard scoreboard and {N,Z,C} writeback around a fixed-latency 8-bit ALU.
// Latency: op accepted at edge N retires (rf/sreg updated) at edge N+LAT; operand reads are combinational.
// Backpressure: issue_ready drops while a source/dest register or a needed carry flag is still pending.
module alu_writeback_rf #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_writeback_rf_if.slave   bus,
  output logic [2:0]          sreg,
  input  logic [AW-1:0]       dbg_addr,
  output logic [7:0]          dbg_data,
  output logic [15:0]         retire_cnt
);

  // Enough bits to count up to LAT outstanding carry writers.
  localparam int FPW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    CL_NONE,
    CL_SHIFT,
    CL_MUL,
    CL_LOGIC,
    CL_ARITH
  } cls_e;

  // Classes whose retire rewrites the carry flag.
  function automatic logic writes_c(input cls_e c);
    return (c == CL_SHIFT) || (c == CL_MUL) || (c == CL_ARITH);
  endfunction

  // Architectural state
  logic [7:0]     rf_q [NREGS];
  logic [7:0]     rf_d [NREGS];
  logic [2:0]     sreg_q, sreg_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [FPW-1:0] flag_pending_q, flag_pending_d;
  logic [15:0]    retire_cnt_q, retire_cnt_d;

  // Tracking pipeline: stage 0 is filled at accept, stage LAT-1 retires.
  // The opcode is kept in decoded form since only its class matters at retire.
  logic           vld_q [LAT];
  cls_e           cls_q [LAT];
  logic [AW-1:0]  rd_q  [LAT];

  // Issue-side decode
  cls_e           iss_cls;
  logic           iss_uses_ci;
  logic [AW-1:0]  iss_pair;
  logic           hazard;
  logic           accept;
  logic [NREGS-1:0] set_mask;

  // Retire-side view
  logic           ret_vld;
  cls_e           ret_cls;
  logic [AW-1:0]  ret_rd;
  logic [NREGS-1:0] clr_mask;

  assign ret_vld = vld_q[LAT-1];
  assign ret_cls = cls_q[LAT-1];
  assign ret_rd  = rd_q[LAT-1];

  // Opcode class and carry-in usage of the op being presented
  always_comb begin
    iss_cls = CL_NONE;
    casez (bus.issue_opcode)
      8'b0000_????: iss_cls = CL_SHIFT;
      8'b0100_????: iss_cls = CL_MUL;
      8'b1000_????,
      8'b1001_????,
      8'b1010_????,
      8'b1011_??00: iss_cls = CL_LOGIC;
      8'b11??_????: iss_cls = CL_ARITH;
      default:      iss_cls = CL_NONE;
    endcase
    iss_uses_ci = ((bus.issue_opcode[7:4] == 4'b0000) && bus.issue_opcode[1]) ||
                  ((bus.issue_opcode[7:6] == 2'b11)   && bus.issue_opcode[4]);
  end

  // The other half of a MUL destination pair.
  assign iss_pair = {bus.issue_rd[AW-1:1], ~bus.issue_rd[0]};

  // Interlock: registered pending bits only, so a register retiring this cycle still stalls.
  always_comb begin
    hazard = pending_q[bus.issue_rd] | pending_q[bus.issue_rr];
    if ((iss_cls == CL_MUL) && pending_q[iss_pair]) hazard = 1'b1;
    if (iss_uses_ci && (flag_pending_q != '0))      hazard = 1'b1;
  end

  assign bus.issue_ready = ~hazard;
  assign accept          = bus.issue_valid & ~hazard;

  // Registers claimed by the accepted op and released by the retiring op
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept) begin
      case (iss_cls)
        CL_SHIFT, CL_LOGIC, CL_ARITH: set_mask[bus.issue_rd] = 1'b1;
        CL_MUL: begin
          set_mask[{bus.issue_rd[AW-1:1], 1'b0}] = 1'b1;
          set_mask[{bus.issue_rd[AW-1:1], 1'b1}] = 1'b1;
        end
        default: ;
      endcase
    end
    if (ret_vld) begin
      case (ret_cls)
        CL_SHIFT, CL_LOGIC, CL_ARITH: clr_mask[ret_rd] = 1'b1;
        CL_MUL: begin
          clr_mask[{ret_rd[AW-1:1], 1'b0}] = 1'b1;
          clr_mask[{ret_rd[AW-1:1], 1'b1}] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard and counters next state; a new claim beats a same-cycle release
  always_comb begin
    pending_d      = (pending_q & ~clr_mask) | set_mask;
    flag_pending_d = flag_pending_q;
    if (accept && writes_c(iss_cls) && !(ret_vld && writes_c(ret_cls)))
      flag_pending_d = flag_pending_q + FPW'(1);
    else if (!(accept && writes_c(iss_cls)) && ret_vld && writes_c(ret_cls))
      flag_pending_d = flag_pending_q - FPW'(1);
    retire_cnt_d = retire_cnt_q + (ret_vld ? 16'd1 : 16'd0);
  end

  // Writeback of the retiring op into rf and {N,Z,C}
  always_comb begin
    for (int i = 0; i < NREGS; i++) rf_d[i] = rf_q[i];
    sreg_d = sreg_q;
    if (ret_vld) begin
      case (ret_cls)
        CL_SHIFT, CL_ARITH: begin
          rf_d[ret_rd] = bus.alu_data[7:0];
          sreg_d       = {bus.alu_no, bus.alu_zo, bus.alu_co};
        end
        CL_MUL: begin
          rf_d[{ret_rd[AW-1:1], 1'b0}] = bus.alu_data[7:0];
          rf_d[{ret_rd[AW-1:1], 1'b1}] = bus.alu_data[15:8];
          sreg_d = {sreg_q[2], bus.alu_zo, bus.alu_co};
        end
        CL_LOGIC: begin
          // ALU flags are stale for these opcodes; derive N/Z from the result.
          rf_d[ret_rd] = bus.alu_data[7:0];
          sreg_d = {bus.alu_data[7], (bus.alu_data[7:0] == 8'h00), sreg_q[0]};
        end
        default: ;
      endcase
    end
  end

  // State registers; reset also discards every in-flight op
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      sreg_q         <= '0;
      pending_q      <= '0;
      flag_pending_q <= '0;
      retire_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
      sreg_q         <= sreg_d;
      pending_q      <= pending_d;
      flag_pending_q <= flag_pending_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  // Tracking pipeline shifting one stage per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        cls_q[i] <= CL_NONE;
        rd_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      cls_q[0] <= iss_cls;
      rd_q[0]  <= bus.issue_rd;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        cls_q[i] <= cls_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
    end
  end

  assign bus.alu_data_rd = rf_q[bus.issue_rd];
  assign bus.alu_data_rr = rf_q[bus.issue_rr];
  assign bus.alu_ci      = sreg_q[0];
  assign bus.alu_opcode  = bus.issue_opcode;
  assign sreg            = sreg_q;
  assign dbg_data        = rf_q[dbg_addr];
  assign retire_cnt      = retire_cnt_q;

endmodule

// File: tb/tb_alu_writeback_rf.sv
// Directed bench for alu_writeback_rf; the bench plays the ALU, returning results for each op.
// Latency: ALU results are driven in the cycle before the retire edge (accept edge + 2).
// Backpressure: issue attempts wait on issue_ready with a bounded cycle budget.
module tb_alu_writeback_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sreg;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [15:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int ops   = 0;   // ops accepted since last reset == expected retire count once drained

  always #5 clk = ~clk;

  alu_writeback_rf_if #(.AW(4)) bus ();

  alu_writeback_rf #(.NREGS(16), .AW(4), .LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sreg       (sreg),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic set_alu(input logic [15:0] data, input logic co, input logic no, input logic zo);
    bus.alu_data = data;
    bus.alu_co   = co;
    bus.alu_no   = no;
    bus.alu_zo   = zo;
  endtask

  // Present an op, wait (bounded) for ready, return just after the accept edge.
  task automatic issue_wait(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr);
    int n;
    n = 0;
    bus.issue_valid  = 1'b1;
    bus.issue_opcode = op;
    bus.issue_rd     = rd;
    bus.issue_rr     = rr;
    #1;
    while (!bus.issue_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.issue_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout op=%02h: issue_ready stayed 0, required 1", op);
    end else begin
      ops++;
    end
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr,
                       input logic [15:0] data, input logic co, input logic no, input logic zo);
    issue_wait(op, rd, rr);
    set_alu(data, co, no, zo);
    step();
    step();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_opcode = 8'h00; bus.issue_rd = 4'd0; bus.issue_rr = 4'd0;
    set_alu(16'h0000, 1'b0, 1'b0, 1'b0);
    dbg_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL reset_sreg: got %b want 000", sreg); end
    n_cmp++; if (retire_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    peek(4'd4, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rf4: got %02h want 00", d); end
    peek(4'd15, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rf15: got %02h want 00", d); end
  endtask

  task automatic test_load_logic();
    logic [7:0] d;
    // Stale ALU flags all high: LOGIC must ignore them.
    do_op(8'h80, 4'd2, 4'd0, 16'h005A, 1'b1, 1'b1, 1'b1);
    peek(4'd2, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL load_rf2: got %02h want 5a", d); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL load_sreg: got %b want 000", sreg); end
    do_op(8'hA0, 4'd3, 4'd0, 16'hFF5A, 1'b1, 1'b1, 1'b1);
    peek(4'd3, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL load_rf3: got %02h want 5a", d); end
    // NEG class: N from bit 7 of the result.
    do_op(8'hB0, 4'd7, 4'd0, 16'h0080, 1'b1, 1'b0, 1'b1);
    peek(4'd7, d);
    n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL neg_rf7: got %02h want 80", d); end
    n_cmp++; if (sreg !== 3'b100) begin n_bad++; $display("FAIL neg_sreg: got %b want 100", sreg); end
  endtask

  task automatic test_mul();
    logic [7:0] d;
    do_op(8'h40, 4'd5, 4'd7, 16'hC350, 1'b1, 1'b0, 1'b0);
    peek(4'd4, d);
    n_cmp++; if (d !== 8'h50) begin n_bad++; $display("FAIL mul_lo: got %02h want 50", d); end
    peek(4'd5, d);
    n_cmp++; if (d !== 8'hC3) begin n_bad++; $display("FAIL mul_hi: got %02h want c3", d); end
    n_cmp++; if (sreg !== 3'b101) begin n_bad++; $display("FAIL mul_sreg: got %b want 101", sreg); end
  endtask

  task automatic test_xor();
    logic [7:0] d;
    bus.issue_valid = 1'b1; bus.issue_opcode = 8'h90; bus.issue_rd = 4'd2; bus.issue_rr = 4'd3;
    #1;
    n_cmp++; if (bus.alu_data_rd !== 8'h5A) begin n_bad++; $display("FAIL xor_opa: got %02h want 5a", bus.alu_data_rd); end
    n_cmp++; if (bus.alu_data_rr !== 8'h5A) begin n_bad++; $display("FAIL xor_opb: got %02h want 5a", bus.alu_data_rr); end
    n_cmp++; if (bus.alu_opcode !== 8'h90) begin n_bad++; $display("FAIL xor_opcode: got %02h want 90", bus.alu_opcode); end
    issue_wait(8'h90, 4'd2, 4'd3);
    set_alu(16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    peek(4'd2, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL xor_early: got %02h want 5a", d); end
    step();
    peek(4'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL xor_rf2: got %02h want 00", d); end
    n_cmp++; if (sreg !== 3'b011) begin n_bad++; $display("FAIL xor_sreg: got %b want 011", sreg); end
  endtask

  task automatic test_raw_hazard();
    logic [7:0] d;
    issue_wait(8'hC0, 4'd1, 4'd2);
    set_alu(16'h0033, 1'b0, 1'b0, 1'b0);
    bus.issue_valid = 1'b1; bus.issue_opcode = 8'hC0; bus.issue_rd = 4'd6; bus.issue_rr = 4'd1;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall1: got %b want 0", bus.issue_ready); end
    step();
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall2: got %b want 0", bus.issue_ready); end
    step();
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_release: got %b want 1", bus.issue_ready); end
    n_cmp++; if (bus.alu_data_rr !== 8'h33) begin n_bad++; $display("FAIL raw_operand: got %02h want 33", bus.alu_data_rr); end
    do_op(8'hC0, 4'd6, 4'd1, 16'h0044, 1'b0, 1'b0, 1'b0);
    peek(4'd6, d);
    n_cmp++; if (d !== 8'h44) begin n_bad++; $display("FAIL raw_rf6: got %02h want 44", d); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL raw_sreg: got %b want 000", sreg); end
  endtask

  task automatic test_flag_interlock();
    logic [7:0] d;
    issue_wait(8'h00, 4'd8, 4'd8);          // LSL
    set_alu(16'h0010, 1'b1, 1'b0, 1'b0);
    bus.issue_valid = 1'b1; bus.issue_opcode = 8'h02; bus.issue_rd = 4'd9; bus.issue_rr = 4'd9;  // ROL
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL ci_stall1: got %b want 0", bus.issue_ready); end
    n_cmp++; if (bus.alu_ci !== 1'b0) begin n_bad++; $display("FAIL ci_before: got %b want 0", bus.alu_ci); end
    step();
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL ci_stall2: got %b want 0", bus.issue_ready); end
    step();
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL ci_release: got %b want 1", bus.issue_ready); end
    n_cmp++; if (bus.alu_ci !== 1'b1) begin n_bad++; $display("FAIL ci_after: got %b want 1", bus.alu_ci); end
    do_op(8'h02, 4'd9, 4'd9, 16'h0021, 1'b0, 1'b0, 1'b0);
    peek(4'd9, d);
    n_cmp++; if (d !== 8'h21) begin n_bad++; $display("FAIL rol_rf9: got %02h want 21", d); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL rol_sreg: got %b want 000", sreg); end
  endtask

  task automatic test_undefined();
    logic [7:0] d;
    do_op(8'h10, 4'd4, 4'd5, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    peek(4'd4, d);
    n_cmp++; if (d !== 8'h50) begin n_bad++; $display("FAIL undef_rf4: got %02h want 50", d); end
    peek(4'd5, d);
    n_cmp++; if (d !== 8'hC3) begin n_bad++; $display("FAIL undef_rf5: got %02h want c3", d); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL undef_sreg: got %b want 000", sreg); end
    n_cmp++; if (retire_cnt !== 16'(ops)) begin n_bad++; $display("FAIL undef_cnt: got %0d want %0d", retire_cnt, ops); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bus.issue_valid = 1'b1; bus.issue_opcode = 8'h80; bus.issue_rd = 4'd10; bus.issue_rr = 4'd0;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready: got %b want 1", bus.issue_ready); end
    step(); ops++;
    bus.issue_rd = 4'd11;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_b_ready: got %b want 1", bus.issue_ready); end
    step(); ops++;
    bus.issue_rd = 4'd12;
    set_alu(16'h0011, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_c_ready: got %b want 1", bus.issue_ready); end
    step(); ops++;
    bus.issue_valid = 1'b0;
    set_alu(16'h0022, 1'b1, 1'b1, 1'b1);
    step();
    set_alu(16'h0033, 1'b1, 1'b1, 1'b1);
    step();
    peek(4'd10, d);
    n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL b2b_rf10: got %02h want 11", d); end
    peek(4'd11, d);
    n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL b2b_rf11: got %02h want 22", d); end
    peek(4'd12, d);
    n_cmp++; if (d !== 8'h33) begin n_bad++; $display("FAIL b2b_rf12: got %02h want 33", d); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL b2b_sreg: got %b want 000", sreg); end
    n_cmp++; if (retire_cnt !== 16'(ops)) begin n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", retire_cnt, ops); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] d;
    bus.issue_valid = 1'b1; bus.issue_opcode = 8'h00; bus.issue_rd = 4'd13; bus.issue_rr = 4'd0;
    step();                                  // SHIFT to r13 accepted
    bus.issue_opcode = 8'h80; bus.issue_rd = 4'd14;
    step();                                  // LOGIC to r14 accepted
    bus.issue_valid = 1'b0;
    set_alu(16'h0077, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    step();                                  // reset edge where r13 would have retired
    rst = 1'b1;
    ops = 0;
    bus.issue_opcode = 8'h02; bus.issue_rd = 4'd13; bus.issue_rr = 4'd14;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.issue_ready); end
    n_cmp++; if (sreg !== 3'b000) begin n_bad++; $display("FAIL rstmid_sreg: got %b want 000", sreg); end
    n_cmp++; if (retire_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", retire_cnt); end
    peek(4'd13, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_rf13: got %02h want 00", d); end
    peek(4'd4, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_rf4: got %02h want 00", d); end
    step();                                  // edge where r14 would have retired
    peek(4'd14, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_rf14: got %02h want 00", d); end
    n_cmp++; if (retire_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_cnt2: got %0d want 0", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_logic();
    test_mul();
    test_xor();
    test_raw_hazard();
    test_flag_interlock();
    test_undefined();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_writeback_rf.md
Name: alu_writeback_rf

Overview:
- Register file, scoreboard and status-flag writeback stage wrapped around the 8-bit ALU.
- Supplies operands and carry-in to the ALU at issue.
- Tracks each issued op through the ALU's fixed 2-cycle latency.
- Retires the ALU result into the destination register(s) and updates the status register {N,Z,C} per opcode class. Interlocks issue on pending hazards.

Parameters:
- NREGS, 16, number of 8-bit general registers
- AW, 4, register address width (log2 NREGS)
- LAT, 2, issue-to-result latency of the ALU in cycles

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- issue_valid  in  1  op presented this cycle
- issue_ready  out  1  op accepted when issue_valid & issue_ready
- issue_opcode  in  8  ALU opcode
- issue_rd  in  AW  destination / first source register
- issue_rr  in  AW  second source register
- alu_data_rd  out  8  rf[issue_rd], combinational read
- alu_data_rr  out  8  rf[issue_rr], combinational read
- alu_ci  out  1  current SREG.C
- alu_opcode  out  8  issue_opcode pass-through
- alu_data  in  16  ALU data_o
- alu_co  in  1  ALU carry out
- alu_no  in  1  ALU negative out
- alu_zo  in  1  ALU zero out
- sreg  out  3  {N,Z,C}
- dbg_addr  in  AW  debug read address
- dbg_data  out  8  rf[dbg_addr], combinational
- retire_cnt  out  16  count of retired ops, wraps at 0xFFFF->0

Behaviour:
- Reset (rst==0 at clock edge): all rf entries, sreg, pending mask, flag_pending counter, LAT-deep valid/opcode/dest pipeline and retire_cnt all become 0. issue_ready is 1 after reset.
- Reset mid-operation drops all in-flight ops with no writeback.
- Accept: issue_valid & issue_ready at edge N. The tracking pipeline captures {opcode, rd}. The op retires at edge N+LAT, using alu_data/flags present in that cycle.
- Opcode classes (X = don't care):
  - SHIFT 0000XXXX: write alu_data[7:0] to rd; flags C,N,Z from alu_co, alu_no, alu_zo.
  - MUL 0100XXXX: write alu_data[7:0] to {rd[AW-1:1],0} and alu_data[15:8] to {rd[AW-1:1],1}. Flags C,Z from ALU; N unchanged.
  - LOGIC 1000/1001/1010XXXX and NEG 1011XX00: write alu_data[7:0] to rd. Compute Z=(alu_data[7:0]==0) and N=alu_data[7] locally, because the ALU leaves its flags stale for these. C unchanged.
  - ARITH 1100–1111XXXX: write alu_data[7:0] to rd; flags C,N,Z from ALU.
  - All other opcodes: accepted and retired (retire_cnt increments), with no rf or sreg change.
- Scoreboard:
  - pending[r] is set at accept for each register the op writes (both pair registers for MUL), and cleared at its retire.
  - If a set and a clear hit the same register in the same cycle, set wins.
  - flag_pending counts accepted-but-unretired ops that modify C.
  - issue_ready = 0 if any of: pending[issue_rd]; pending[issue_rr]; the MUL pair register is pending; or issue_opcode uses ci (0000XX10, 0000XX11, 1101XXXX, 1111XXXX) and flag_pending != 0.
  - No bypass: a register being retired this cycle is still pending for the hazard check.
- Back-to-back independent ops issue every cycle; at most LAT ops are in flight.
- retire_cnt increments by 1 at every retire edge.

Test Plan:
- Reset, load rf via directed MUL/LOGIC ops, then XOR r2=0x5A with r3=0x5A → rf[2]=0x00 at N+2; sreg Z=1, N=0, C unchanged.
- MUL issue_rd=5, ALU returns 0xC350 → rf[4]=0x50, rf[5]=0xC3, Z=0, C=1, N unchanged.
- ADD r1 then immediately ADD reading r1 → issue_ready=0 for 2 cycles, then accepted; second result uses the updated r1.
- LSL sets C=1, then ROL issued next cycle → stalled until LSL retires; ROL sees alu_ci=1.
- Undefined opcode 0x10 → no rf/sreg change; retire_cnt +1.
- Assert rst=0 with 2 ops in flight → no writeback; all rf=0, sreg=0, retire_cnt=0, issue_ready=1 on the following cycle.
